// File: rtl/player_bullet_collision.sv
// Player bullet stage: launches one bullet per fire press, steps it upward on a
// fixed tick, tests it against the enemy box every cycle and keeps the hit score.
module player_bullet_collision #(
   parameter int SCREEN_WIDTH = 640,
   parameter int ENEMY_WIDTH  = 40,
   parameter int ENEMY_HEIGHT = 40,
   parameter int PLAYER_W     = 40,
   parameter int PLAYER_Y     = 440,
   parameter int BULLET_W     = 2,
   parameter int BULLET_H     = 8,
   parameter int BULLET_STEP  = 4,
   parameter int MOVE_DELAY   = 250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fire,
   input  logic       respawn,
   input  logic [9:0] player_x,
   input  logic [9:0] enemy_x,
   input  logic [9:0] enemy_y,
   input  logic [9:0] xPixel,
   input  logic [9:0] yPixel,
   output logic [9:0] bullet_x,
   output logic [9:0] bullet_y,
   output logic       bullet_active,
   output logic       hit,
   output logic       enemy_alive,
   output logic [7:0] score,
   output logic       bullet_color
);

   localparam int CW = (MOVE_DELAY > 1) ? $clog2(MOVE_DELAY) : 1;
   localparam logic [CW-1:0] TICK_MAX   = CW'(MOVE_DELAY - 1);
   localparam logic [10:0]   CENTER_OFF = 11'(PLAYER_W / 2 - BULLET_W / 2);
   localparam logic [10:0]   X_MAX      = 11'(SCREEN_WIDTH - BULLET_W);
   localparam logic [10:0]   BW_M1      = 11'(BULLET_W - 1);
   localparam logic [10:0]   BH_M1      = 11'(BULLET_H - 1);
   localparam logic [10:0]   EW         = 11'(ENEMY_WIDTH);
   localparam logic [10:0]   EH         = 11'(ENEMY_HEIGHT);
   localparam logic [9:0]    LAUNCH_Y   = 10'(PLAYER_Y - BULLET_H);
   localparam logic [9:0]    STEP       = 10'(BULLET_STEP);

   typedef enum logic [1:0] {IDLE, FLIGHT, HIT} state_t;

   state_t         state, state_next;
   logic           fire_d;
   logic [CW-1:0]  tick_cnt;
   logic           fire_rise, tick, overlap;
   logic [10:0]    launch_x_raw;
   logic [9:0]     launch_x;
   logic [10:0]    bx, by, ex, ey, px, py;

   always_comb begin
      fire_rise    = fire & ~fire_d;
      tick         = (tick_cnt == TICK_MAX);
      bx           = {1'b0, bullet_x};
      by           = {1'b0, bullet_y};
      ex           = {1'b0, enemy_x};
      ey           = {1'b0, enemy_y};
      px           = {1'b0, xPixel};
      py           = {1'b0, yPixel};
      launch_x_raw = {1'b0, player_x} + CENTER_OFF;
      launch_x     = (launch_x_raw > X_MAX) ? X_MAX[9:0] : launch_x_raw[9:0];
      // 11-bit sums so the far edges of the boxes never wrap
      overlap      = enemy_alive && (bx + BW_M1 >= ex) && (bx <= ex + EW)
                                 && (by + BH_M1 >= ey) && (by <= ey + EH);
      bullet_color = bullet_active && (px >= bx) && (px <= bx + BW_M1)
                                   && (py >= by) && (py <= by + BH_M1);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      hit        = 1'b0;
      case (state)
         IDLE:    if (fire_rise) state_next = FLIGHT;
         FLIGHT: begin
            if (overlap)                          state_next = HIT;
            else if (tick && (bullet_y < STEP))   state_next = IDLE;
         end
         HIT: begin
            hit        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bullet_x      <= '0;
         bullet_y      <= '0;
         bullet_active <= 1'b0;
         enemy_alive   <= 1'b1;
         score         <= '0;
         tick_cnt      <= '0;
         fire_d        <= 1'b0;
      end else begin
         fire_d      <= fire;
         // respawn overrides the kill when both land in the same cycle
         enemy_alive <= respawn | (enemy_alive & (state != HIT));
         case (state)
            IDLE: begin
               if (fire_rise) begin
                  bullet_x      <= launch_x;
                  bullet_y      <= LAUNCH_Y;
                  tick_cnt      <= '0;
                  bullet_active <= 1'b1;
               end
            end
            FLIGHT: begin
               if (!overlap) begin
                  tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                  if (tick) begin
                     if (bullet_y < STEP) bullet_active <= 1'b0;
                     else                 bullet_y      <= bullet_y - STEP;
                  end
               end
            end
            HIT: begin
               bullet_active <= 1'b0;
               if (score != '1) score <= score + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_player_bullet_collision.sv
// Randomised bench for player_bullet_collision; expected trajectory, hits and
// score come from arithmetic on the bullet rules, not from the RTL structure.
module tb_player_bullet_collision;

   localparam int SW = 640, EWD = 40, EHT = 40, PW = 40, PY = 440;
   localparam int BW = 2, BH = 8, STEP = 4, MD = 4;
   localparam int LY = PY - BH;

   logic       clk = 1'b0;
   logic       rst, fire, respawn;
   logic [9:0] player_x, enemy_x, enemy_y, xPixel, yPixel;
   logic [9:0] bullet_x, bullet_y;
   logic       bullet_active, hit, enemy_alive, bullet_color;
   logic [7:0] score;

   int tests = 0;
   int fails = 0;
   int m_score = 0;
   bit m_alive = 1'b1;

   player_bullet_collision #(.MOVE_DELAY(MD)) dut (
      .clk(clk), .rst(rst), .fire(fire), .respawn(respawn),
      .player_x(player_x), .enemy_x(enemy_x), .enemy_y(enemy_y),
      .xPixel(xPixel), .yPixel(yPixel),
      .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
      .hit(hit), .enemy_alive(enemy_alive), .score(score), .bullet_color(bullet_color)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_overlap(int bx, int by, int ex, int ey);
      return (bx + BW - 1 >= ex) && (bx <= ex + EWD) && (by + BH - 1 >= ey) && (by <= ey + EHT);
   endfunction

   function automatic int m_launch_x(int px);
      int x = px + PW / 2 - BW / 2;
      return (x > SW - BW) ? SW - BW : x;
   endfunction

   // fmode: 0 release after launch, 1 hold throughout, 2 hold 20 cycles then re-press
   task automatic fly(input int px, input int ex, input int ey, input bit resp_on_hit,
                      input int fmode, output bit got_hit);
      int bx, k, y, xp, yp;
      bit done, want_c;
      player_x = 10'(px); enemy_x = 10'(ex); enemy_y = 10'(ey);
      fire = 1'b0; step();
      fire = 1'b1; step();
      bx = m_launch_x(px); k = 0; done = 1'b0; got_hit = 1'b0;
      while (!done && k < 1000) begin
         y = LY - STEP * (k / MD);
         tests++;
         if (bullet_active !== 1'b1 || bullet_x !== bx[9:0] || bullet_y !== y[9:0] || hit !== 1'b0) begin
            fails++;
            $display("FAIL flight k=%0d: active=%b x=%0d y=%0d hit=%b, want active=1 x=%0d y=%0d hit=0",
                     k, bullet_active, bullet_x, bullet_y, hit, bx, y);
         end
         xp = bx - 2 + int'($urandom_range(0, 5));
         yp = y - 2 + int'($urandom_range(0, 11));
         if (yp < 0) yp = 0;
         xPixel = 10'(xp); yPixel = 10'(yp);
         #1;
         want_c = (xp >= bx) && (xp <= bx + BW - 1) && (yp >= y) && (yp <= y + BH - 1);
         tests++;
         if (bullet_color !== want_c) begin
            fails++;
            $display("FAIL color k=%0d pix=(%0d,%0d): got %b want %b", k, xp, yp, bullet_color, want_c);
         end
         if (fmode == 0)      fire = 1'b0;
         else if (fmode == 2) fire = (k < 20) || (k == 30);
         if (m_alive && m_overlap(bx, y, ex, ey)) begin
            step();
            tests++;
            if (hit !== 1'b1 || bullet_active !== 1'b1 || bullet_y !== y[9:0] || score !== 8'(m_score)) begin
               fails++;
               $display("FAIL hit_cycle: hit=%b active=%b y=%0d score=%0d, want 1 1 %0d %0d",
                        hit, bullet_active, bullet_y, score, y, m_score);
            end
            respawn = resp_on_hit;
            step();
            respawn = 1'b0;
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_alive = resp_on_hit;
            tests++;
            if (hit !== 1'b0 || bullet_active !== 1'b0 || score !== 8'(m_score) || enemy_alive !== m_alive) begin
               fails++;
               $display("FAIL after_hit: hit=%b active=%b score=%0d alive=%b, want 0 0 %0d %b",
                        hit, bullet_active, score, enemy_alive, m_score, m_alive);
            end
            got_hit = 1'b1; done = 1'b1;
         end else if (k % MD == MD - 1 && y < STEP) begin
            step();
            tests++;
            if (bullet_active !== 1'b0 || hit !== 1'b0 || bullet_y !== y[9:0] ||
                score !== 8'(m_score) || enemy_alive !== m_alive) begin
               fails++;
               $display("FAIL after_miss: active=%b hit=%b y=%0d score=%0d alive=%b, want 0 0 %0d %0d %b",
                        bullet_active, hit, bullet_y, score, enemy_alive, y, m_score, m_alive);
            end
            done = 1'b1;
         end else begin
            step();
            k++;
         end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL flight_timeout: bullet still active after %0d cycles, want resolved", k);
      end
   endtask

   task automatic test_reset();
      int xp, yp;
      fire = 1'b0; respawn = 1'b0; rst = 1'b1;
      player_x = '0; enemy_x = 10'd500; enemy_y = 10'd100; xPixel = '0; yPixel = '0;
      step(); step();
      tests++;
      if (bullet_x !== 10'd0 || bullet_y !== 10'd0 || bullet_active !== 1'b0 || hit !== 1'b0 ||
          enemy_alive !== 1'b1 || score !== 8'd0) begin
         fails++;
         $display("FAIL reset_vals: x=%0d y=%0d active=%b hit=%b alive=%b score=%0d, want 0 0 0 0 1 0",
                  bullet_x, bullet_y, bullet_active, hit, enemy_alive, score);
      end
      for (int i = 0; i < 6; i++) begin
         xp = int'($urandom_range(0, 15)); yp = int'($urandom_range(0, 15));
         xPixel = 10'(xp); yPixel = 10'(yp);
         #1;
         tests++;
         if (bullet_color !== 1'b0) begin
            fails++;
            $display("FAIL reset_color pix=(%0d,%0d): got %b want 0", xp, yp, bullet_color);
         end
      end
      rst = 1'b0; m_score = 0; m_alive = 1'b1;
      step();
   endtask

   task automatic test_launch();
      bit g;
      fly(100, 500, 100, 1'b0, 0, g);
      tests++;
      if (g !== 1'b0) begin
         fails++;
         $display("FAIL launch_miss: got hit=%b want 0", g);
      end
   endtask

   task automatic test_hold_refire();
      bit g;
      fly(300, 0, 0, 1'b0, 2, g);
      fly(300, 0, 0, 1'b0, 1, g);
      for (int i = 0; i < 10; i++) begin
         step();
         tests++;
         if (bullet_active !== 1'b0) begin
            fails++;
            $display("FAIL hold_no_refire cycle %0d: active=%b want 0", i, bullet_active);
         end
      end
      fire = 1'b0; step();
   endtask

   task automatic test_hit();
      bit g;
      fly(100, 118, 400, 1'b0, 0, g);
      tests++;
      if (g !== 1'b1 || m_score != 1) begin
         fails++;
         $display("FAIL hit_happened: got hit=%b score_model=%0d want 1 1", g, m_score);
      end
      fly(100, 118, 400, 1'b0, 0, g);
      tests++;
      if (g !== 1'b0) begin
         fails++;
         $display("FAIL dead_enemy_refire: got hit=%b want 0", g);
      end
   endtask

   task automatic test_random();
      bit g;
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            respawn = 1'b1; step(); respawn = 1'b0;
            m_alive = 1'b1;
            tests++;
            if (enemy_alive !== 1'b1) begin
               fails++;
               $display("FAIL respawn_idle: alive=%b want 1", enemy_alive);
            end
         end
         fly(int'($urandom_range(0, 1023)), int'($urandom_range(0, 600)),
             int'($urandom_range(200, 470)), 1'($urandom_range(0, 1)), 0, g);
      end
   endtask

   task automatic test_edges();
      bit g;
      fly(620, 0, 0, 1'b0, 0, g);
      fly(1023, 0, 0, 1'b0, 0, g);
      respawn = 1'b1; step(); respawn = 1'b0; m_alive = 1'b1;
      fly(100, 118, 400, 1'b1, 0, g);
      tests++;
      if (g !== 1'b1 || enemy_alive !== 1'b1) begin
         fails++;
         $display("FAIL respawn_coincident: hit=%b alive=%b want 1 1", g, enemy_alive);
      end
      for (int n = 0; n < 300 && m_score < 255; n++) fly(100, 118, 400, 1'b1, 0, g);
      fly(100, 118, 400, 1'b1, 0, g);
      tests++;
      if (score !== 8'd255) begin
         fails++;
         $display("FAIL score_saturate: score=%0d want 255", score);
      end
   endtask

   task automatic test_reset_midflight();
      fire = 1'b0; player_x = 10'd200; enemy_x = 10'd0; enemy_y = 10'd0; step();
      fire = 1'b1; step(); fire = 1'b0;
      repeat (6) step();
      tests++;
      if (bullet_active !== 1'b1) begin
         fails++;
         $display("FAIL midflight_active: active=%b want 1", bullet_active);
      end
      rst = 1'b1; step();
      tests++;
      if (bullet_active !== 1'b0 || score !== 8'd0 || enemy_alive !== 1'b1 || hit !== 1'b0) begin
         fails++;
         $display("FAIL midflight_reset: active=%b score=%0d alive=%b hit=%b, want 0 0 1 0",
                  bullet_active, score, enemy_alive, hit);
      end
      rst = 1'b0; m_score = 0; m_alive = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_launch();
      test_hold_refire();
      test_hit();
      test_random();
      test_edges();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
